// File: rtl/qdrc_pkg.sv
// Shared types and constants for the two-port QDR request arbiter.
// Used by qdrc_arbiter and its read-tag pipeline.
package qdrc_pkg;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int RD_LATENCY_MIN = 2;
  localparam int RD_LATENCY_MAX = 31;

  typedef struct packed {
    logic valid;
    logic port;
  } tag_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } grant_e;

endpackage

// File: rtl/qdrc_arbiter_if.sv
// Requester, controller and read-return signals of the QDR arbiter.
// The arbiter uses the slave modport; the environment uses master.
interface qdrc_arbiter_if #(
  parameter int DATA_WIDTH = 36,
  parameter int BW_WIDTH   = 4,
  parameter int ADDR_WIDTH = 21
);

  logic                  phy_rdy;
  logic                  a_req;
  logic                  b_req;
  logic                  a_wr_en;
  logic                  b_wr_en;
  logic                  a_rd_en;
  logic                  b_rd_en;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] a_wr_data;
  logic [DATA_WIDTH-1:0] b_wr_data;
  logic [BW_WIDTH-1:0]   a_be;
  logic [BW_WIDTH-1:0]   b_be;
  logic                  a_ack;
  logic                  b_ack;
  logic                  a_rd_dvld;
  logic                  b_rd_dvld;
  logic [DATA_WIDTH-1:0] a_rd_data;
  logic [DATA_WIDTH-1:0] b_rd_data;
  logic                  qdr_wr_en;
  logic                  qdr_rd_en;
  logic [ADDR_WIDTH-1:0] qdr_addr;
  logic [DATA_WIDTH-1:0] qdr_wr_data;
  logic [BW_WIDTH-1:0]   qdr_be;
  logic [DATA_WIDTH-1:0] qdr_rd_data;

  modport slave (
    input  phy_rdy, a_req, b_req, a_wr_en, b_wr_en, a_rd_en, b_rd_en,
    input  a_addr, b_addr, a_wr_data, b_wr_data, a_be, b_be, qdr_rd_data,
    output a_ack, b_ack, a_rd_dvld, b_rd_dvld, a_rd_data, b_rd_data,
    output qdr_wr_en, qdr_rd_en, qdr_addr, qdr_wr_data, qdr_be
  );

  modport master (
    output phy_rdy, a_req, b_req, a_wr_en, b_wr_en, a_rd_en, b_rd_en,
    output a_addr, b_addr, a_wr_data, b_wr_data, a_be, b_be, qdr_rd_data,
    input  a_ack, b_ack, a_rd_dvld, b_rd_dvld, a_rd_data, b_rd_data,
    input  qdr_wr_en, qdr_rd_en, qdr_addr, qdr_wr_data, qdr_be
  );

endinterface

// File: rtl/qdrc_arb_tag_pipe.sv
// Fixed-depth shift register of read tags {valid, port}; a tag pushed with
// a read command pops out DEPTH cycles later, aligned with its read data.
module qdrc_arb_tag_pipe
  import qdrc_pkg::*;
#(
  parameter int DEPTH = 10
) (
  input  logic clk,
  input  logic clr,
  input  tag_t push_tag,
  output tag_t pop_tag
);

  tag_t [DEPTH-1:0] tags_q;
  tag_t [DEPTH-1:0] tags_d;

  always_comb begin
    tags_d = {tags_q[DEPTH-2:0], push_tag};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      tags_q <= '0;
    end else begin
      tags_q <= tags_d;
    end
  end

  assign pop_tag = tags_q[DEPTH-1];

endmodule

// File: rtl/qdrc_arbiter.sv
// Two-port arbiter in front of the QDR controller user interface.
// Define QDRC_ARB_FAIR_EN for round robin; otherwise port A has fixed priority.
module qdrc_arbiter
  import qdrc_pkg::*;
#(
  parameter int DATA_WIDTH = 36,
  parameter int BW_WIDTH   = 4,
  parameter int ADDR_WIDTH = 21,
  parameter int RD_LATENCY = 10
) (
  input logic           clk,
  input logic           reset,
  qdrc_arbiter_if.slave bus
);

  // Handshake: a requester holds req (with wr_en/rd_en and payload) until
  // its ack; ack is combinational and high for exactly the accepting cycle,
  // and the command appears as a one-cycle registered qdr_* strobe next cycle.

  // Out-of-range latencies are clamped so the pipe always elaborates.
  localparam int TAG_DEPTH = (RD_LATENCY < RD_LATENCY_MIN) ? RD_LATENCY_MIN :
                             (RD_LATENCY > RD_LATENCY_MAX) ? RD_LATENCY_MAX :
                             RD_LATENCY;

  logic                  a_elig;
  logic                  b_elig;
  grant_e                grant;
  logic                  last_grant_q, last_grant_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  port_q, port_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BW_WIDTH-1:0]   be_q, be_d;
  tag_t                  push_tag;
  tag_t                  pop_tag;

  assign a_elig = bus.a_req & (bus.a_wr_en | bus.a_rd_en);
  assign b_elig = bus.b_req & (bus.b_wr_en | bus.b_rd_en);

  always_comb begin
    grant = GNT_NONE;
    if (!reset && bus.phy_rdy) begin
      if (a_elig && b_elig) begin
`ifdef QDRC_ARB_FAIR_EN
        grant = (last_grant_q == PORT_A) ? GNT_B : GNT_A;
`else
        grant = GNT_A;
`endif
      end else if (a_elig) begin
        grant = GNT_A;
      end else if (b_elig) begin
        grant = GNT_B;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    port_d       = port_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    case (grant)
      GNT_A: begin
        last_grant_d = PORT_A;
        wr_en_d      = bus.a_wr_en;
        rd_en_d      = bus.a_rd_en;
        port_d       = PORT_A;
        addr_d       = bus.a_addr;
        wdata_d      = bus.a_wr_data;
        be_d         = bus.a_be;
      end
      GNT_B: begin
        last_grant_d = PORT_B;
        wr_en_d      = bus.b_wr_en;
        rd_en_d      = bus.b_rd_en;
        port_d       = PORT_B;
        addr_d       = bus.b_addr;
        wdata_d      = bus.b_wr_data;
        be_d         = bus.b_be;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= PORT_B;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      port_q       <= PORT_A;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      port_q       <= port_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
    end
  end

  // The tag enters alongside the issued read so it retires with the data.
  always_comb begin
    push_tag       = '0;
    push_tag.valid = rd_en_q;
    push_tag.port  = port_q;
  end

  qdrc_arb_tag_pipe #(
    .DEPTH(TAG_DEPTH)
  ) u_tag_pipe (
    .clk     (clk),
    .clr     (reset),
    .push_tag(push_tag),
    .pop_tag (pop_tag)
  );

  assign bus.a_ack       = (grant == GNT_A);
  assign bus.b_ack       = (grant == GNT_B);
  assign bus.a_rd_dvld   = !reset && pop_tag.valid && (pop_tag.port == PORT_A);
  assign bus.b_rd_dvld   = !reset && pop_tag.valid && (pop_tag.port == PORT_B);
  assign bus.a_rd_data   = bus.qdr_rd_data;
  assign bus.b_rd_data   = bus.qdr_rd_data;
  assign bus.qdr_wr_en   = wr_en_q;
  assign bus.qdr_rd_en   = rd_en_q;
  assign bus.qdr_addr    = addr_q;
  assign bus.qdr_wr_data = wdata_q;
  assign bus.qdr_be      = be_q;

endmodule

// File: tb/tb_qdrc_arbiter.sv
// Self-checking bench for qdrc_arbiter: scenario tasks plus a cycle monitor
// compared against a rule-level model of grants, commands and read returns.
module tb_qdrc_arbiter;
  import qdrc_pkg::*;

  localparam int DW = 36;
  localparam int BW = 4;
  localparam int AW = 21;
  localparam int L  = 10;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  qdrc_arbiter_if #(.DATA_WIDTH(DW), .BW_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

  qdrc_arbiter #(
    .DATA_WIDTH(DW), .BW_WIDTH(BW), .ADDR_WIDTH(AW), .RD_LATENCY(L)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // ---------------- controller model: memory with fixed read latency
  logic [DW-1:0] ctl_mem [int];
  logic [DW-1:0] ret_d [64];
  bit            ret_v [64];

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (ret_v[cyc % 64]) begin
      bus.qdr_rd_data = ret_d[cyc % 64];
      ret_v[cyc % 64] = 1'b0;
    end else begin
      bus.qdr_rd_data = DW'({$urandom(), $urandom()});
    end
  end

  always @(negedge clk) begin
    if (bus.qdr_rd_en === 1'b1) begin
      ret_d[(cyc + L) % 64] = ctl_mem.exists(int'(bus.qdr_addr)) ? ctl_mem[int'(bus.qdr_addr)] : '0;
      ret_v[(cyc + L) % 64] = 1'b1;
    end
    if (bus.qdr_wr_en === 1'b1) ctl_mem[int'(bus.qdr_addr)] = bus.qdr_wr_data;
  end

  // ---------------- reference model and scoreboard
  typedef struct {
    int            due;
    logic          port;
    logic [DW-1:0] data;
  } ret_t;

  ret_t          exp_q[$];
  logic [DW-1:0] shadow [int];
  logic          m_wr = 0, m_rd = 0, m_last = 1;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [BW-1:0] m_be = '0;

  always @(negedge clk) begin : monitor
    logic a_el, b_el, e_adv, e_bdv, g_a, g_b;
    logic [DW-1:0] e_dat;
    ret_t r;
    n_checks++;
    if ({bus.qdr_wr_en, bus.qdr_rd_en} !== {m_wr, m_rd}) begin
      n_fail++;
      $display("FAIL mon_cmd_strobe cyc=%0d got wr/rd=%b%b expected %b%b", cyc, bus.qdr_wr_en, bus.qdr_rd_en, m_wr, m_rd);
    end
    n_checks++;
    if ({bus.qdr_addr, bus.qdr_wr_data, bus.qdr_be} !== {m_addr, m_data, m_be}) begin
      n_fail++;
      $display("FAIL mon_cmd_payload cyc=%0d got %h/%h/%h expected %h/%h/%h", cyc, bus.qdr_addr, bus.qdr_wr_data, bus.qdr_be, m_addr, m_data, m_be);
    end
    e_adv = 0; e_bdv = 0; e_dat = '0;
    if (!reset && exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      e_adv = (r.port == PORT_A);
      e_bdv = (r.port == PORT_B);
      e_dat = r.data;
    end
    n_checks++;
    if ({bus.a_rd_dvld, bus.b_rd_dvld} !== {e_adv, e_bdv}) begin
      n_fail++;
      $display("FAIL mon_dvld cyc=%0d got a/b=%b%b expected %b%b", cyc, bus.a_rd_dvld, bus.b_rd_dvld, e_adv, e_bdv);
    end
    if (e_adv || e_bdv) begin
      n_checks++;
      if ((e_adv ? bus.a_rd_data : bus.b_rd_data) !== e_dat) begin
        n_fail++;
        $display("FAIL mon_rd_data cyc=%0d got %h expected %h", cyc, e_adv ? bus.a_rd_data : bus.b_rd_data, e_dat);
      end
    end
    a_el = bus.a_req && (bus.a_wr_en || bus.a_rd_en);
    b_el = bus.b_req && (bus.b_wr_en || bus.b_rd_en);
    g_a = 0; g_b = 0;
    if (!reset && bus.phy_rdy) begin
      if (a_el && b_el) begin
`ifdef QDRC_ARB_FAIR_EN
        g_a = m_last;
        g_b = !m_last;
`else
        g_a = 1;
`endif
      end else begin
        g_a = a_el;
        g_b = b_el;
      end
    end
    n_checks++;
    if ({bus.a_ack, bus.b_ack} !== {g_a, g_b}) begin
      n_fail++;
      $display("FAIL mon_ack cyc=%0d got a/b=%b%b expected %b%b", cyc, bus.a_ack, bus.b_ack, g_a, g_b);
    end
    if (reset) begin
      {m_wr, m_rd, m_addr, m_data, m_be} = '0;
      m_last = 1;
      exp_q.delete();
    end else if (g_a || g_b) begin
      m_wr   = g_a ? bus.a_wr_en : bus.b_wr_en;
      m_rd   = g_a ? bus.a_rd_en : bus.b_rd_en;
      m_addr = g_a ? bus.a_addr : bus.b_addr;
      m_data = g_a ? bus.a_wr_data : bus.b_wr_data;
      m_be   = g_a ? bus.a_be : bus.b_be;
      if (m_rd) begin
        r.due  = cyc + 1 + L;
        r.port = g_b;
        r.data = shadow.exists(int'(m_addr)) ? shadow[int'(m_addr)] : '0;
        exp_q.push_back(r);
      end
      if (m_wr) shadow[int'(m_addr)] = m_data;
      m_last = g_b;
    end else begin
      m_wr = 0;
      m_rd = 0;
    end
  end

  // ---------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic req, input logic wr, input logic rd, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [BW-1:0] be);
    bus.a_req = req; bus.a_wr_en = wr; bus.a_rd_en = rd;
    bus.a_addr = addr; bus.a_wr_data = data; bus.a_be = be;
  endtask

  task automatic drive_b(input logic req, input logic wr, input logic rd, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [BW-1:0] be);
    bus.b_req = req; bus.b_wr_en = wr; bus.b_rd_en = rd;
    bus.b_addr = addr; bus.b_wr_data = data; bus.b_be = be;
  endtask

  task automatic idle_ports();
    drive_a(0, 0, 0, '0, '0, '0);
    drive_b(0, 0, 0, '0, '0, '0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.phy_rdy = 1;
      drive_a(1, 1, 0, 21'h5, 36'h123, 4'hf);
      drive_b(1, 0, 1, 21'h6, '0, 4'hf);
      @(negedge clk);
      n_checks++;
      if ({bus.a_ack, bus.b_ack} !== 2'b00) begin
        n_fail++; $display("FAIL reset_ack got %b%b expected 00", bus.a_ack, bus.b_ack);
      end
    end
    tick();
    reset = 0;
    idle_ports();
    @(negedge clk);
    n_checks++;
    if ({bus.qdr_wr_en, bus.qdr_rd_en, bus.qdr_addr, bus.qdr_wr_data, bus.qdr_be,
         bus.a_rd_dvld, bus.b_rd_dvld} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got wr=%b rd=%b addr=%h expected all zero", bus.qdr_wr_en, bus.qdr_rd_en, bus.qdr_addr);
    end
  endtask

  task automatic test_phy_rdy();
    logic [AW-1:0] ad = AW'($urandom_range(0, 255));
    logic [DW-1:0] dt = DW'({$urandom(), $urandom()});
    for (int i = 0; i < 20; i++) begin
      tick();
      bus.phy_rdy = 0;
      drive_a(1, 1, 0, ad, dt, 4'hf);
      @(negedge clk);
      n_checks++;
      if (bus.a_ack !== 1'b0 || bus.qdr_wr_en !== 1'b0) begin
        n_fail++; $display("FAIL phy_hold got ack=%b wr=%b expected 0/0", bus.a_ack, bus.qdr_wr_en);
      end
    end
    tick();
    bus.phy_rdy = 1;
    @(negedge clk);
    n_checks++;
    if (bus.a_ack !== 1'b1) begin
      n_fail++; $display("FAIL phy_release_ack got %b expected 1", bus.a_ack);
    end
    tick();
    idle_ports();
    @(negedge clk);
    n_checks++;
    if (bus.qdr_wr_en !== 1'b1 || bus.qdr_addr !== ad || bus.qdr_wr_data !== dt) begin
      n_fail++; $display("FAIL phy_release_cmd got wr=%b %h/%h expected 1 %h/%h", bus.qdr_wr_en, bus.qdr_addr, bus.qdr_wr_data, ad, dt);
    end
  endtask

  task automatic test_write_read();
    int ack_cyc, got;
    logic [DW-1:0] got_d;
    tick();
    drive_a(1, 1, 0, 21'h10, 36'hABC, 4'hf);
    @(negedge clk);
    tick();
    drive_a(1, 0, 1, 21'h10, '0, 4'hf);
    @(negedge clk);
    ack_cyc = cyc;
    n_checks++;
    if (bus.a_ack !== 1'b1) begin
      n_fail++; $display("FAIL wr_rd_ack got %b expected 1", bus.a_ack);
    end
    tick();
    idle_ports();
    got = -1;
    got_d = '0;
    for (int k = 0; k < L + 8; k++) begin
      @(negedge clk);
      if (bus.a_rd_dvld === 1'b1 && got < 0) begin
        got = cyc;
        got_d = bus.a_rd_data;
      end
      n_checks++;
      if (bus.b_rd_dvld !== 1'b0) begin
        n_fail++; $display("FAIL wr_rd_b_dvld got %b expected 0", bus.b_rd_dvld);
      end
    end
    n_checks++;
    if (got - ack_cyc != L + 1 || got_d !== 36'hABC) begin
      n_fail++; $display("FAIL wr_rd_return got delay=%0d data=%h expected %0d/abc", got - ack_cyc, got_d, L + 1);
    end
  endtask

  task automatic test_both_reads();
    int na = 0, nb = 0;
    logic prev_a = 0, a_got = 1, b_got = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      drive_a(1, 1, 0, AW'(32 + i), DW'({$urandom(), $urandom()}), 4'hf);
      bus.b_req = 0;
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      if (a_got) drive_a(1, 0, 1, AW'($urandom_range(32, 39)), '0, 4'hf);
      if (b_got) drive_b(1, 0, 1, AW'($urandom_range(32, 39)), '0, 4'hf);
      @(negedge clk);
      a_got = bus.a_ack;
      b_got = bus.b_ack;
      na += int'(bus.a_ack);
      nb += int'(bus.b_ack);
`ifdef QDRC_ARB_FAIR_EN
      n_checks++;
      if ((bus.a_ack ^ bus.b_ack) !== 1'b1 || (k > 0 && bus.a_ack === prev_a)) begin
        n_fail++; $display("FAIL rr_alternate k=%0d got a/b=%b%b prev_a=%b", k, bus.a_ack, bus.b_ack, prev_a);
      end
`else
      n_checks++;
      if ({bus.a_ack, bus.b_ack} !== 2'b10) begin
        n_fail++; $display("FAIL fixed_prio k=%0d got a/b=%b%b expected 10", k, bus.a_ack, bus.b_ack);
      end
`endif
      prev_a = bus.a_ack;
    end
    tick();
    idle_ports();
    drain(L + 4);
    n_checks++;
`ifdef QDRC_ARB_FAIR_EN
    if (na != 4 || nb != 4) begin
`else
    if (na != 8 || nb != 0) begin
`endif
      n_fail++; $display("FAIL both_reads_counts got a=%0d b=%0d", na, nb);
    end
  endtask

  task automatic test_rd_wr_same();
    int cmd_cyc, got = -1;
    tick();
    drive_b(1, 1, 1, 21'h30, 36'h5A5A5, 4'h3);
    @(negedge clk);
    n_checks++;
    if (bus.b_ack !== 1'b1) begin
      n_fail++; $display("FAIL rdwr_ack got %b expected 1", bus.b_ack);
    end
    tick();
    idle_ports();
    @(negedge clk);
    cmd_cyc = cyc;
    n_checks++;
    if ({bus.qdr_rd_en, bus.qdr_wr_en} !== 2'b11 || bus.qdr_addr !== 21'h30) begin
      n_fail++; $display("FAIL rdwr_cmd got rd/wr=%b%b addr=%h expected 11/30", bus.qdr_rd_en, bus.qdr_wr_en, bus.qdr_addr);
    end
    for (int k = 1; k <= L + 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_checks++;
        if ({bus.qdr_rd_en, bus.qdr_wr_en} !== 2'b00) begin
          n_fail++; $display("FAIL rdwr_single got rd/wr=%b%b expected 00", bus.qdr_rd_en, bus.qdr_wr_en);
        end
      end
      if (bus.b_rd_dvld === 1'b1 && got < 0) got = cyc;
      n_checks++;
      if (bus.a_rd_dvld !== 1'b0) begin
        n_fail++; $display("FAIL rdwr_a_dvld got %b expected 0", bus.a_rd_dvld);
      end
    end
    n_checks++;
    if (got - cmd_cyc != L) begin
      n_fail++; $display("FAIL rdwr_return got delay=%0d expected %0d", got - cmd_cyc, L);
    end
  endtask

  task automatic test_reset_inflight();
    for (int i = 0; i < 3; i++) begin
      tick();
      drive_a(1, 0, 1, AW'(32 + i), '0, 4'hf);
      @(negedge clk);
    end
    tick();
    idle_ports();
    reset = 1;
    @(negedge clk);
    tick();
    reset = 0;
    @(negedge clk);
    n_checks++;
    if ({bus.qdr_wr_en, bus.qdr_rd_en, bus.qdr_addr, bus.qdr_wr_data, bus.qdr_be} !== '0) begin
      n_fail++; $display("FAIL rst_inflight_cmd got rd=%b addr=%h expected zero", bus.qdr_rd_en, bus.qdr_addr);
    end
    for (int k = 0; k < L + 6; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.a_rd_dvld, bus.b_rd_dvld} !== 2'b00) begin
        n_fail++; $display("FAIL rst_inflight_dvld got a/b=%b%b expected 00", bus.a_rd_dvld, bus.b_rd_dvld);
      end
    end
  endtask

  task automatic test_ineligible();
    tick();
    drive_a(1, 0, 0, 21'h44, '0, 4'hf);
    drive_b(1, 0, 1, 21'h21, '0, 4'hf);
    @(negedge clk);
    n_checks++;
    if ({bus.a_ack, bus.b_ack} !== 2'b01) begin
      n_fail++; $display("FAIL inelig_grant got a/b=%b%b expected 01", bus.a_ack, bus.b_ack);
    end
    tick();
    bus.b_req = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.a_ack !== 1'b0 || (k > 0 && {bus.qdr_wr_en, bus.qdr_rd_en} !== 2'b00)) begin
        n_fail++; $display("FAIL inelig_hold k=%0d got ack=%b wr/rd=%b%b", k, bus.a_ack, bus.qdr_wr_en, bus.qdr_rd_en);
      end
      if (k < 3) tick();
    end
    tick();
    idle_ports();
    drain(L + 4);
  endtask

  task automatic test_random();
    logic a_got = 1, b_got = 1;
    for (int i = 0; i < 400; i++) begin
      tick();
      bus.phy_rdy = ($urandom_range(0, 9) != 0);
      reset = ($urandom_range(0, 99) == 0);
      if (a_got || !(bus.a_wr_en || bus.a_rd_en))
        drive_a(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), AW'($urandom_range(0, 15)),
                DW'({$urandom(), $urandom()}), BW'($urandom));
      if (b_got || !(bus.b_wr_en || bus.b_rd_en))
        drive_b(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), AW'($urandom_range(0, 15)),
                DW'({$urandom(), $urandom()}), BW'($urandom));
      @(negedge clk);
      a_got = bus.a_ack;
      b_got = bus.b_ack;
    end
    tick();
    reset = 0;
    bus.phy_rdy = 1;
    idle_ports();
    drain(L + 4);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL random_drain got %0d pending returns expected 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    bus.phy_rdy = 0;
    bus.qdr_rd_data = '0;
    idle_ports();
    test_reset();
    test_phy_rdy();
    test_write_read();
    test_both_reads();
    test_rd_wr_same();
    test_reset_inflight();
    test_ineligible();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
